piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0; 0 sends bit 0 first, 1 sends bit WIDTH-1 first.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port clear  input  1  reset; synchronous and active-high.
REQ-005 Port p_in  input  WIDTH  parallel word to transmit; sampled only on a load handshake.
REQ-006 Port load_valid  input  1  p_in holds a word to send.
REQ-007 Port load_ready  output  1  block accepts a word this cycle; combinational.
REQ-008 Port shift_en  input  1  shift enable; 0 freezes transmission.
REQ-009 Port s_out  output  1  serial data bit; registered.
REQ-010 Port s_valid  output  1  s_out carries a frame bit; registered.
REQ-011 Port s_first  output  1  current bit is the first of a word; registered.
REQ-012 Port s_last  output  1  current bit is the last of a word; registered.

Function
REQ-013 Internal state: WIDTH-bit shift register, bit counter of ceil(log2(WIDTH)) bits, two-state FSM IDLE/SHIFT.
REQ-014 Handshake = load_valid AND load_ready at a rising edge; p_in captured at that edge.
REQ-015 load_ready = 1 in IDLE; in SHIFT, load_ready = 1 only when counter = WIDTH-1 and shift_en = 1; otherwise 0.
REQ-016 IDLE: s_out = 0, s_valid = 0, s_first = 0, s_last = 0.
REQ-017 Handshake in IDLE: next state SHIFT, counter = 0; from the following cycle s_out = first bit per MSB_FIRST, s_valid = 1, s_first = 1.
REQ-018 Latency: first bit appears on s_out exactly 1 cycle after the handshake edge.
REQ-019 SHIFT with shift_en = 1 and counter < WIDTH-1: shift by one position toward the send direction, counter increments, s_first = 0.
REQ-020 s_last = 1 exactly while counter = WIDTH-1 in SHIFT.
REQ-021 SHIFT with shift_en = 0: shift register, counter, and all outputs hold; no handshake is possible.
REQ-022 Last bit with shift_en = 1 and no handshake: next state IDLE, outputs per REQ-016.
REQ-023 Last bit with shift_en = 1 and handshake: new word loaded, counter = 0, state remains SHIFT, next cycle carries the new first bit with s_first = 1; no idle gap between words.
REQ-024 Each word occupies exactly WIDTH cycles on s_out while shift_en stays 1.
REQ-025 p_in changes outside a handshake have no effect on transmission.
REQ-026 Bit order for MSB_FIRST = 0 matches the team's serial-in receiver: after WIDTH receiver shifts, the receiver's parallel output equals the transmitted word.

Reset
REQ-027 clear = 1 at a rising edge forces IDLE, counter = 0, shift register = 0, and outputs per REQ-016 from the next cycle; this includes mid-frame, and the partial word is dropped.
REQ-028 clear has priority over handshake and shift_en; load_ready = 0 while clear = 1.
REQ-029 After clear deasserts, a handshake is accepted in the first cycle of IDLE.

Verification
REQ-030 WIDTH=4, MSB_FIRST=0, load 4'b1011 -> s_out 1,1,0,1 on cycles 1-4; s_first on cycle 1; s_last on cycle 4; s_valid=0 on cycle 5.
REQ-031 Back-to-back 4'b1011 then 4'b0110, second handshake on the last-bit cycle -> 8 contiguous bits 1,1,0,1,0,1,1,0; s_valid stays 1 throughout; s_first on cycles 1 and 5.
REQ-032 shift_en=0 for 3 cycles while bit 2 of 4'b1011 is presented -> s_out holds 0 for 4 cycles total; then 1 follows; load_valid during the stall is not accepted.
REQ-033 clear asserted after 2 bits of 4'b1110 -> next cycle s_valid=0, s_out=0, load_ready=1; a fresh 4'b0101 then sends 1,0,1,0.
REQ-034 MSB_FIRST=1 with 4'b1011 -> s_out 1,0,1,1.
REQ-035 Loopback into the 4-bit serial-in receiver sharing clk/clear with 4'b1011 -> receiver parallel output = 4'b1011 four cycles after the first bit.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out word serializer with a valid/ready load port.
// Frames carry first/last markers and chain back-to-back without gaps.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_first,
    output logic             s_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             s_first_q, s_first_d;
    logic             s_last_q, s_last_d;

    logic             at_last;
    logic             hs;
    logic [WIDTH-1:0] sreg_sh;
    logic [CW-1:0]    cnt_inc;

    // Bit that sits at the send end of a word
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Handshake decode: ready in IDLE, or on an enabled last-bit cycle
    always_comb begin
        at_last    = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready = !clear && ((state_q == IDLE) || (at_last && shift_en));
        hs         = load_valid && load_ready;
        sreg_sh    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        cnt_inc    = cnt_q + 1'b1;
    end

    // Next-state and next-output computation; default is hold
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        s_valid_d = s_valid_q;
        s_first_d = s_first_q;
        s_last_d  = s_last_q;
        if (hs) begin
            state_d   = SHIFT;
            sreg_d    = p_in;
            cnt_d     = '0;
            s_out_d   = head_bit(p_in);
            s_valid_d = 1'b1;
            s_first_d = 1'b1;
            s_last_d  = 1'b0;
        end else if ((state_q == SHIFT) && shift_en) begin
            if (at_last) begin
                state_d   = IDLE;
                sreg_d    = '0;
                cnt_d     = '0;
                s_out_d   = 1'b0;
                s_valid_d = 1'b0;
                s_first_d = 1'b0;
                s_last_d  = 1'b0;
            end else begin
                sreg_d    = sreg_sh;
                cnt_d     = cnt_inc;
                s_out_d   = head_bit(sreg_sh);
                s_valid_d = 1'b1;
                s_first_d = 1'b0;
                s_last_d  = (cnt_inc == LAST);
            end
        end
    end

    // State and registered outputs; clear drops any partial word
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_first_q <= 1'b0;
            s_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_first_q <= s_first_d;
            s_last_q  <= s_last_d;
        end
    end

    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
    assign s_first = s_first_q;
    assign s_last  = s_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: LSB-first and MSB-first
// instances driven in parallel against a word/index reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] p_in = '0;
    logic       lv = 1'b0;
    logic       se = 1'b0;

    logic lr_l, so_l, sv_l, sf_l, sl_l;
    logic lr_m, so_m, sv_m, sf_m, sl_m;

    int checks = 0;
    int errors = 0;

    // reference model: whether a word is on the line, which word, which bit
    bit         m_busy = 1'b0;
    logic [3:0] m_word = '0;
    int         m_idx = 0;

    // values captured by cyc for the tests to compare
    logic       rdy_l, rdy_m, rdy_e;
    logic [3:0] out_l, out_m, exp_l, exp_m;

    // loopback receiver: shifts in at the top, first bit ends in bit 0
    logic [3:0] rx;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clear(clear), .p_in(p_in),
        .load_valid(lv), .load_ready(lr_l), .shift_en(se),
        .s_out(so_l), .s_valid(sv_l), .s_first(sf_l), .s_last(sl_l)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clear(clear), .p_in(p_in),
        .load_valid(lv), .load_ready(lr_m), .shift_en(se),
        .s_out(so_m), .s_valid(sv_m), .s_first(sf_m), .s_last(sl_m)
    );

    always_ff @(posedge clk) begin
        if (clear) rx <= '0;
        else if (sv_l) rx <= {so_l, rx[3:1]};
    end

    function automatic logic [3:0] model_out(input bit msb);
        logic b;
        if (!m_busy) return 4'b0000;
        b = msb ? m_word[3 - m_idx] : m_word[m_idx];
        return {b, 1'b1, m_idx == 0, m_idx == 3};
    endfunction

    // one clock: drive inputs, capture ready, step model, capture outputs
    task automatic cyc(input logic c, input logic v,
                       input logic [3:0] p, input logic s);
        @(negedge clk);
        clear = c; lv = v; p_in = p; se = s;
        #1;
        rdy_l = lr_l;
        rdy_m = lr_m;
        rdy_e = !c && (!m_busy || (m_idx == 3 && s));
        if (c) begin
            m_busy = 1'b0;
        end else if (rdy_e && v) begin
            m_busy = 1'b1; m_word = p; m_idx = 0;
        end else if (m_busy && s) begin
            if (m_idx == 3) m_busy = 1'b0;
            else m_idx++;
        end
        @(posedge clk);
        #1;
        out_l = {so_l, sv_l, sf_l, sl_l};
        out_m = {so_m, sv_m, sf_m, sl_m};
        exp_l = model_out(1'b0);
        exp_m = model_out(1'b1);
    endtask

    task automatic test_reset();
        cyc(1, 1, 4'b1011, 1);
        checks++;
        if (rdy_l !== 1'b0 || rdy_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 0", rdy_l, rdy_m);
        end
        checks++;
        if (out_l !== 4'b0000 || out_m !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out got %b/%b want 0000", out_l, out_m);
        end
        cyc(0, 1, 4'b1011, 1);
        checks++;
        if (rdy_l !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_ready got %b want 1", rdy_l);
        end
        checks++;
        if (out_l !== 4'b1110) begin
            errors++;
            $display("FAIL reset_first_hs got %b want 1110", out_l);
        end
    endtask

    task automatic test_basic();
        logic [3:0] w;
        w = 4'b1011;
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, w, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_l !== {w[i], 1'b1, i == 0, i == 3}) begin
                errors++;
                $display("FAIL basic_lsb bit%0d got %b want %b",
                         i, out_l, {w[i], 1'b1, i == 0, i == 3});
            end
            checks++;
            if (out_m !== {w[3 - i], 1'b1, i == 0, i == 3}) begin
                errors++;
                $display("FAIL basic_msb bit%0d got %b want %b",
                         i, out_m, {w[3 - i], 1'b1, i == 0, i == 3});
            end
            cyc(0, 0, $urandom, 1);
        end
        checks++;
        if (out_l !== 4'b0000 || out_m !== 4'b0000) begin
            errors++;
            $display("FAIL basic_idle got %b/%b want 0000", out_l, out_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b0110_1011;
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b1011, 1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_l !== {bits[k], 1'b1, (k % 4) == 0, (k % 4) == 3}) begin
                errors++;
                $display("FAIL b2b bit%0d got %b want %b", k, out_l,
                         {bits[k], 1'b1, (k % 4) == 0, (k % 4) == 3});
            end
            if (k == 3) begin
                cyc(0, 1, 4'b0110, 1);
                checks++;
                if (rdy_l !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready got %b want 1", rdy_l);
                end
            end else begin
                cyc(0, 0, 4'b0000, 1);
            end
        end
        checks++;
        if (out_l !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_idle got %b want 0000", out_l);
        end
    endtask

    task automatic test_stall();
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b1011, 1);
        cyc(0, 0, 4'b0000, 1);
        cyc(0, 0, 4'b0000, 1);
        checks++;
        if (out_l !== 4'b0100) begin
            errors++;
            $display("FAIL stall_bit2 got %b want 0100", out_l);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 4'b1111, 0);
            checks++;
            if (rdy_l !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready%0d got %b want 0", i, rdy_l);
            end
            checks++;
            if (out_l !== 4'b0100) begin
                errors++;
                $display("FAIL stall_hold%0d got %b want 0100", i, out_l);
            end
        end
        cyc(0, 0, 4'b0000, 1);
        checks++;
        if (out_l !== 4'b1101) begin
            errors++;
            $display("FAIL stall_bit3 got %b want 1101", out_l);
        end
        cyc(0, 0, 4'b0000, 1);
        checks++;
        if (out_l !== 4'b0000) begin
            errors++;
            $display("FAIL stall_after got %b want 0000", out_l);
        end
    endtask

    task automatic test_clear_midframe();
        logic [3:0] w;
        w = 4'b0101;
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b1110, 1);
        cyc(0, 0, 4'b0000, 1);
        cyc(1, 1, 4'b1111, 1);
        checks++;
        if (rdy_l !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready got %b want 0", rdy_l);
        end
        checks++;
        if (out_l !== 4'b0000) begin
            errors++;
            $display("FAIL clr_out got %b want 0000", out_l);
        end
        cyc(0, 1, w, 1);
        checks++;
        if (rdy_l !== 1'b1) begin
            errors++;
            $display("FAIL clr_ready_after got %b want 1", rdy_l);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_l !== {w[i], 1'b1, i == 0, i == 3}) begin
                errors++;
                $display("FAIL clr_fresh bit%0d got %b want %b",
                         i, out_l, {w[i], 1'b1, i == 0, i == 3});
            end
            cyc(0, 0, 4'b0000, 1);
        end
    endtask

    task automatic test_loopback();
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b1011, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'b0000, 1);
        checks++;
        if (rx !== 4'b1011) begin
            errors++;
            $display("FAIL loopback got %b want 1011", rx);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 40) == 0, $urandom % 2,
                4'($urandom), ($urandom % 4) != 0);
            checks++;
            if (rdy_l !== rdy_e || rdy_m !== rdy_e) begin
                errors++;
                $display("FAIL rand_ready n%0d got %b/%b want %b",
                         n, rdy_l, rdy_m, rdy_e);
            end
            checks++;
            if (out_l !== exp_l || out_m !== exp_m) begin
                errors++;
                $display("FAIL rand_out n%0d got %b/%b want %b/%b",
                         n, out_l, out_m, exp_l, exp_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_clear_midframe();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
